// File: rtl/tff_sched_pkg.sv
// Shared types and constants for the round-robin toggle scheduler.
package tff_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2,
    HOLD  = 2'd3
  } sched_state_t;

  localparam int NREQ_DEFAULT = 4;

  // last_grant resets this far below NREQ so requester 0 wins the first arbitration.
  localparam int RST_GRANT_BACKOFF = 1;

endpackage

// File: rtl/tff_core.sv
// Single T flip-flop with asynchronous active-low reset.
module tff_core (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_toggle_sched.sv
// Round-robin scheduler sharing one T flip-flop between NREQ requesters,
// toggling only when needed and holding off new grants after each real toggle.
module tff_toggle_sched
  import tff_sched_pkg::*;
#(
  parameter  int NREQ        = NREQ_DEFAULT,
  parameter  int HOLD_CYCLES = 2,
  localparam int GW          = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] want,
  output logic [NREQ-1:0] ack,
  output logic            t,
  output logic            q,
  output logic            busy,
  output logic [GW-1:0]   last_grant
);

  localparam int            HW        = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [GW-1:0] RST_GRANT = GW'(NREQ - RST_GRANT_BACKOFF);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  sched_state_t  state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic          toggled_q, toggled_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [GW-1:0] sel_idx;
  logic          sel_found;

  tff_core u_tff (
    .clk (clk),
    .rst (rst),
    .t   (t),
    .q   (q)
  );

  // First pending requester strictly after last_grant, wrapping modulo NREQ.
  always_comb begin : arbiter
    logic [GW-1:0] idx;
    sel_found = 1'b0;
    sel_idx   = last_grant_q;
    idx       = last_grant_q;
    for (int i = 1; i <= NREQ; i++) begin
      idx = GW'((int'(last_grant_q) + i) % NREQ);
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    toggled_d    = toggled_q;
    hold_cnt_d   = hold_cnt_q;
    t            = 1'b0;
    ack          = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d        = sel_idx;
          last_grant_d = sel_idx;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        t         = want[gnt_q] ^ q;
        toggled_d = t;
        state_d   = ACK;
      end
      ACK: begin
        ack[gnt_q] = 1'b1;
        hold_cnt_d = HOLD_LOAD;
        state_d    = (toggled_q && (HOLD_CYCLES > 0)) ? HOLD : IDLE;
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q - HW'(1);
        if (hold_cnt_q <= HW'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_grant_q <= RST_GRANT;
      toggled_q    <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      toggled_q    <= toggled_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_tff_toggle_sched.sv
// Bench for tff_toggle_sched: a transaction-schedule model checked every cycle
// on two instances (HOLD_CYCLES 2 and 0), plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_tff_toggle_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i   [2];
  logic [3:0] want_i  [2];
  logic [3:0] ack_o   [2];
  logic       t_o     [2];
  logic       q_o     [2];
  logic       busy_o  [2];
  logic [1:0] lg_o    [2];

  always #5 clk = ~clk;

  tff_toggle_sched #(.NREQ(4), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req_i[0]), .want(want_i[0]), .ack(ack_o[0]),
    .t(t_o[0]), .q(q_o[0]), .busy(busy_o[0]), .last_grant(lg_o[0])
  );

  tff_toggle_sched #(.NREQ(4), .HOLD_CYCLES(0)) dut_nohold (
    .clk(clk), .rst(rst), .req(req_i[1]), .want(want_i[1]), .ack(ack_o[1]),
    .t(t_o[1]), .q(q_o[1]), .busy(busy_o[1]), .last_grant(lg_o[1])
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int scen = 0;
  int base = 0;
  int hold_of [2] = '{2, 0};

  // Model: a transaction granted in IDLE cycle gc toggles (if needed) in gc+1,
  // acks in gc+2, and the scheduler is idle again from free_at onward.
  int         gc      [2];
  int         free_at [2];
  logic [1:0] g       [2];
  logic [1:0] lg      [2];
  logic       mq      [2];
  logic [3:0] ack_seen [2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: actual %0h required %0h", nm, d, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int off;
    for (int d = 0; d < 2; d++) begin
      logic       exp_t;
      logic [3:0] exp_ack;
      logic       exp_busy;
      logic [1:0] idx;
      logic       found;
      if (!rst) begin
        gc[d] = -10; free_at[d] = 0; mq[d] = 1'b0; lg[d] = 2'd3; g[d] = 2'd0;
        chk("rst_t", d, 32'(t_o[d]), 32'd0);
        chk("rst_q", d, 32'(q_o[d]), 32'd0);
        chk("rst_ack", d, 32'(ack_o[d]), 32'd0);
        chk("rst_busy", d, 32'(busy_o[d]), 32'd0);
        chk("rst_lg", d, 32'(lg_o[d]), 32'd3);
      end else begin
        exp_t    = 1'b0;
        exp_ack  = 4'b0000;
        if (cyc == gc[d] + 1) exp_t = want_i[d][g[d]] ^ mq[d];
        if (cyc == gc[d] + 2) exp_ack = 4'b0001 << g[d];
        exp_busy = (cyc > gc[d]) && (cyc < free_at[d]);
        chk("t", d, 32'(t_o[d]), 32'(exp_t));
        chk("ack", d, 32'(ack_o[d]), 32'(exp_ack));
        chk("busy", d, 32'(busy_o[d]), 32'(exp_busy));
        chk("q", d, 32'(q_o[d]), 32'(mq[d]));
        chk("last_grant", d, 32'(lg_o[d]), 32'(lg[d]));
        if (cyc == gc[d] + 1) begin
          free_at[d] = cyc + 2 + (exp_t ? hold_of[d] : 0);
          if (exp_t) mq[d] = ~mq[d];
        end
        if (cyc >= free_at[d] && req_i[d] != 4'b0000) begin
          found = 1'b0;
          idx   = lg[d];
          for (int i = 1; i <= 4; i++) begin
            idx = lg[d] + 2'(i);
            if (!found && req_i[d][idx]) begin
              found = 1'b1;
              g[d]  = idx;
            end
          end
          lg[d]      = g[d];
          gc[d]      = cyc;
          free_at[d] = cyc + 3;
        end
      end
      ack_seen[d] = ack_o[d];
    end

    off = cyc - base;
    case (scen)
      1: begin
        if (off == 1) begin chk("s1_t", 0, 32'(t_o[0]), 32'd1); chk("s1_lg", 0, 32'(lg_o[0]), 32'd0); end
        if (off == 2) begin chk("s1_ack", 0, 32'(ack_o[0]), 32'h1); chk("s1_q", 0, 32'(q_o[0]), 32'd1); end
        if (off == 4) chk("s1_busy_hold", 0, 32'(busy_o[0]), 32'd1);
        if (off == 5) chk("s1_busy_done", 0, 32'(busy_o[0]), 32'd0);
      end
      2: begin
        if (off == 1) chk("s2_t", 0, 32'(t_o[0]), 32'd0);
        if (off == 2) chk("s2_ack", 0, 32'(ack_o[0]), 32'h2);
        if (off == 3) chk("s2_idle", 0, 32'(busy_o[0]), 32'd0);
      end
      3: begin
        if (off == 1)  chk("s3_lg1", 0, 32'(lg_o[0]), 32'd1);
        if (off == 2)  chk("s3_ack1", 0, 32'(ack_o[0]), 32'h2);
        if (off == 5)  chk("s3_ack2", 0, 32'(ack_o[0]), 32'h4);
        if (off == 8)  chk("s3_ack3", 0, 32'(ack_o[0]), 32'h8);
        if (off == 10) chk("s3_lg0", 0, 32'(lg_o[0]), 32'd0);
        if (off == 11) chk("s3_ack0", 0, 32'(ack_o[0]), 32'h1);
      end
      4: begin
        if (off == 1) chk("s4_t_first", 0, 32'(t_o[0]), 32'd1);
        if (off == 4) begin chk("s4_hold_busy", 0, 32'(busy_o[0]), 32'd1); chk("s4_hold_lg", 0, 32'(lg_o[0]), 32'd0); end
        if (off == 5) chk("s4_t_gap", 0, 32'(t_o[0]), 32'd0);
        if (off == 6) begin chk("s4_t_second", 0, 32'(t_o[0]), 32'd1); chk("s4_lg", 0, 32'(lg_o[0]), 32'd1); end
        if (off == 7) chk("s4_ack", 0, 32'(ack_o[0]), 32'h2);
      end
      5: begin
        if (off == 2) chk("s5_q_set", 0, 32'(q_o[0]), 32'd1);
        if (off == 3) begin
          chk("s5_rst_q", 0, 32'(q_o[0]), 32'd0);
          chk("s5_rst_busy", 0, 32'(busy_o[0]), 32'd0);
          chk("s5_rst_ack", 0, 32'(ack_o[0]), 32'd0);
        end
        if (off == 6) chk("s5_lg2", 0, 32'(lg_o[0]), 32'd2);
        if (off == 7) chk("s5_ack2", 0, 32'(ack_o[0]), 32'h4);
      end
      6: begin
        if (off == 1 || off == 4 || off == 7 || off == 10) chk("s6_t", 1, 32'(t_o[1]), 32'd1);
        if (off == 3 || off == 6) chk("s6_no_hold", 1, 32'(busy_o[1]), 32'd0);
      end
      default: ;
    endcase
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) req_i[d] = req_i[d] & ~ack_seen[d];
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_i[d]  = 4'b0000;
      want_i[d] = 4'b0000;
    end
    step(3);
    rst = 1'b1;
    step(2);

    scen = 1; base = cyc; req_i[0] = 4'b0001; want_i[0] = 4'b0001;
    step(8);

    scen = 3; base = cyc; req_i[0] = 4'b1111; want_i[0] = 4'b1111;
    step(13);

    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);

    scen = 2; base = cyc; req_i[0] = 4'b0010; want_i[0] = 4'b0000;
    step(5);

    scen = 4; base = cyc; req_i[0] = 4'b0011; want_i[0] = 4'b0001;
    step(12);

    scen = 5; base = cyc; req_i[0] = 4'b0001; want_i[0] = 4'b0001;
    step(3);
    req_i[0] = 4'b1100; want_i[0] = 4'b0000; rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(7);

    scen = 6; base = cyc;
    for (int k = 0; k < 4; k++) begin
      req_i[1]  = 4'b0001;
      want_i[1] = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      step(3);
    end
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
